// File: rtl/core_pkg.sv
// Shared core definitions: the NOP encoding, the opcode enum used by
// decode_control, and the {pc, inst} entry held by the fetch queue.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b000_0011,
        OP_IMM    = 7'b001_0011,
        OP_AUIPC  = 7'b001_0111,
        OP_STORE  = 7'b010_0011,
        OP_REG    = 7'b011_0011,
        OP_LUI    = 7'b011_0111,
        OP_BRANCH = 7'b110_0011,
        OP_JALR   = 7'b110_0111,
        OP_JAL    = 7'b110_1111,
        OP_SYSTEM = 7'b111_0011
    } inst_type;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x fetch_entry_t registers with one
// synchronous write port and one asynchronous read port. Not reset; validity
// is tracked by the pointers in fetch_queue.
module fetch_queue_mem
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    fetch_entry_t mem [DEPTH];

    // Write the incoming entry into the slot addressed by the write pointer
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= fetch_entry_t'(wr_data);
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. Buffers {pc, inst} pairs and
// presents the head entry (with its opcode) to decode_control, absorbs decode
// stalls, clears on redirect and pulses clear_invalid_counter after reset and
// after every flush.
// Optional build macro: FETCH_QUEUE_BYPASS_EN (zero-latency empty-queue bypass).
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_inst,
    output logic [6:0]             out_opcode,
    output logic                   out_inst_legal,
    output logic                   clear_invalid_counter,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        count_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic               rd_en;
    logic               bypass_active;
    logic               bypass_take;
    logic               was_reset;
    logic               was_flush;
    logic [ENTRY_W-1:0] rd_data;
    fetch_entry_t       wr_entry;
    fetch_entry_t       head;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready = ~reset & ~full;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_active = empty & ~flush & ~reset;
    assign bypass_take   = bypass_active & in_valid & out_ready;
`else
    assign bypass_active = 1'b0;
    assign bypass_take   = 1'b0;
`endif

    // A bypassed entry goes straight to decode and never touches storage
    assign wr_en = push & ~bypass_take & ~flush;
    assign rd_en = pop & ~empty & ~flush;

    assign wr_entry = '{pc: in_pc, inst: in_inst};
    assign head     = fetch_entry_t'(rd_data);

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    // Pointer and occupancy update; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Remember last cycle's reset/flush so decode gets its clear pulse
    always_ff @(posedge clk) begin
        was_reset <= reset;
        was_flush <= flush & ~reset;
    end

    assign clear_invalid_counter = ~reset & (was_reset | was_flush);
    assign count                 = count_q;

    // Head presentation: bypass when enabled, else storage or NOP when empty
    always_comb begin
        out_valid = ~empty;
        out_pc    = head.pc;
        out_inst  = head.inst;
        if (bypass_active) begin
            out_valid = in_valid;
            out_pc    = in_valid ? in_pc : '0;
            out_inst  = in_valid ? in_inst : NOP_INST;
        end else if (empty) begin
            out_pc   = '0;
            out_inst = NOP_INST;
        end
    end

    assign out_opcode     = out_inst[6:0];
    assign out_inst_legal = (out_inst[1:0] == 2'b11) & out_valid;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a {pc, inst} scoreboard.
// Honours FETCH_QUEUE_BYPASS_EN when the design is built with it.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [6:0]  out_opcode;
    logic        out_inst_legal;
    logic        clear_invalid_counter;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_q [$];

    fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (32)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .flush                 (flush),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_pc                 (in_pc),
        .in_inst               (in_inst),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_pc                (out_pc),
        .out_inst              (out_inst),
        .out_opcode            (out_opcode),
        .out_inst_legal        (out_inst_legal),
        .clear_invalid_counter (clear_invalid_counter),
        .count                 (count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, compare any popped head against the
    // scoreboard, advance the model on the clock edge, then return to idle.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic ordy, input logic fl);
        logic        byp;
        logic        do_push;
        logic        do_pop;
        logic [63:0] exp;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = !fl && v && ordy && (model_q.size() == 0);
`endif
        do_push = v && (model_q.size() < DEPTH) && !fl && !byp;
        do_pop  = ordy && (model_q.size() > 0) && !fl;
        if (byp) begin
            checkOutput("bypass_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bypass_pc", out_pc, pc);
        end
        if (do_pop) begin
            exp = model_q[0];
            checkOutput("pop_pc", out_pc, exp[63:32]);
            checkOutput("pop_inst", out_inst, exp[31:0]);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, inst});
        end
        #1;
        checkOutput("count", {29'd0, count}, model_q.size());
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_inst   = '0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_inst", out_inst, NOP);
        checkOutput("rst_out_pc", out_pc, 32'd0);
        checkOutput("rst_clear", {31'd0, clear_invalid_counter}, 32'd0);
        checkOutput("rst_count", {29'd0, count}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rel_clear", {31'd0, clear_invalid_counter}, 32'd1);
        checkOutput("rel_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rel_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rel_out_inst", out_inst, NOP);
        @(posedge clk);
        #1;
        checkOutput("rel_clear_low", {31'd0, clear_invalid_counter}, 32'd0);

        // Fill to full, try a fifth push, then drain in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(i * 4), {16'hA5A5, 8'(i), 8'h33}, 1'b0, 1'b0);
        end
        checkOutput("full_count", {29'd0, count}, 32'd4);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1, 32'h10, 32'hDEAD_0033, 1'b0, 1'b0);
        checkOutput("full_still_4", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        checkOutput("drained_valid", {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop at count 1
        applyStimulus(1'b1, 32'h20, 32'h0000_1033, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h10, 32'h0000_2033, 1'b1, 1'b0);
        checkOutput("pp_count", {29'd0, count}, 32'd1);
        checkOutput("pp_out_pc", out_pc, 32'h10);
        checkOutput("pp_out_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush with three entries and a concurrent push
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h30 + 32'(i * 4), 32'h0000_3033, 1'b0, 1'b0);
        end
        checkOutput("pre_flush_count", {29'd0, count}, 32'd3);
        applyStimulus(1'b1, 32'h3C, 32'h0000_4033, 1'b0, 1'b1);
        checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_clear", {31'd0, clear_invalid_counter}, 32'd1);
        checkOutput("flush_out_pc", out_pc, 32'd0);
        checkOutput("flush_out_inst", out_inst, NOP);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("flush_clear_low", {31'd0, clear_invalid_counter}, 32'd0);
        checkOutput("flush_no_word", {31'd0, out_valid}, 32'd0);

        // Back-to-back flushes keep the clear pulse high
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("b2b_clear_1", {31'd0, clear_invalid_counter}, 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("b2b_clear_2", {31'd0, clear_invalid_counter}, 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("b2b_clear_low", {31'd0, clear_invalid_counter}, 32'd0);

        // Opcode and legality of the head entry
        applyStimulus(1'b1, 32'h50, 32'h0000_0000, 1'b0, 1'b0);
        checkOutput("op_zero", {25'd0, out_opcode}, 32'h00);
        checkOutput("legal_zero", {31'd0, out_inst_legal}, 32'd0);
        applyStimulus(1'b1, 32'h54, 32'h0000_0033, 1'b1, 1'b0);
        checkOutput("op_reg", {25'd0, out_opcode}, 32'h33);
        checkOutput("legal_reg", {31'd0, out_inst_legal}, 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Reset in the middle of operation
        applyStimulus(1'b1, 32'h60, 32'h0000_5033, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h64, 32'h0000_6033, 1'b0, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        model_q.delete();
        #1;
        checkOutput("midrst_count", {29'd0, count}, 32'd0);
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_clear", {31'd0, clear_invalid_counter}, 32'd1);
        @(posedge clk);
        #1;

        // Empty queue, push and consume in the same cycle
        in_valid  = 1'b1;
        in_pc     = 32'h40;
        in_inst   = 32'h0040_0033;
        out_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checkOutput("byp_same_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("byp_same_pc", out_pc, 32'h40);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("byp_count", {29'd0, count}, 32'd0);
        checkOutput("byp_after_valid", {31'd0, out_valid}, 32'd0);
`else
        checkOutput("nobyp_same_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_q.push_back({32'h40, 32'h0040_0033});
        #1;
        checkOutput("nobyp_next_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("nobyp_next_pc", out_pc, 32'h40);
        checkOutput("nobyp_count", {29'd0, count}, 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
